// File: rtl/lrrr_controller.sv
// Lrrr enemy sequencer: parks, spawns after a random delay, flies with periodic
// vertical reversals, explodes on a hit and leaves unscored when its lifetime expires.
module lrrr_controller #(
  parameter int unsigned SPAWN_MIN_FRAMES = 60,
  parameter int unsigned TOGGLE_PERIOD    = 45,
  parameter int unsigned LIFETIME_FRAMES  = 600,
  parameter int unsigned EXPLODE_FRAMES   = 30
) (
  input  logic clk,
  input  logic resetN,
  input  logic startOfFrame,
  input  logic enable,
  input  logic hitPulse,
  output logic idleN,
  output logic toggleY,
  output logic exploding,
  output logic scorePulse
);

  localparam int unsigned CntW = 10;
  localparam int unsigned LfsrW = 8;
  localparam logic [CntW-1:0]  CntMax    = '1;
  localparam logic [CntW-1:0]  SpawnMin  = CntW'(SPAWN_MIN_FRAMES);
  localparam logic [CntW-1:0]  Lifetime  = CntW'(LIFETIME_FRAMES);
  localparam logic [CntW-1:0]  ExplodeW  = CntW'(EXPLODE_FRAMES);
  localparam logic             TogEn     = (TOGGLE_PERIOD != 0);
  localparam logic [CntW-1:0]  TogDiv    = CntW'((TOGGLE_PERIOD == 0) ? 1 : TOGGLE_PERIOD);
  localparam logic [LfsrW-1:0] LfsrSeed  = 8'hA5;

  typedef enum logic [1:0] {
    StOff     = 2'd0,
    StWait    = 2'd1,
    StActive  = 2'd2,
    StExplode = 2'd3
  } stateT;

  stateT            state;
  stateT            stateNext;
  logic [CntW-1:0]  frameCnt;
  logic [CntW-1:0]  sofCnt;
  logic [CntW-1:0]  spawnTarget;
  logic [LfsrW-1:0] lfsr;
  logic             toggleNext;
  logic             scoreNext;

  // Frame count as it stands once the current startOfFrame is counted
  assign sofCnt = (frameCnt == CntMax) ? CntMax : frameCnt + CntW'(1);

  // State register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= StOff;
    else         state <= stateNext;
  end

  // Next-state logic; enable low overrides every other transition
  always_comb begin
    stateNext = state;
    case (state)
      StOff:     if (enable) stateNext = StWait;
      StWait:    if (startOfFrame && (sofCnt >= spawnTarget)) stateNext = StActive;
      StActive: begin
        if (hitPulse)                                       stateNext = StExplode;
        else if (startOfFrame && (sofCnt >= Lifetime))      stateNext = StWait;
      end
      StExplode: if (startOfFrame && (sofCnt >= ExplodeW)) stateNext = StExplode == state ? StWait : state;
      default:   stateNext = StOff;
    endcase
    if (!enable) stateNext = StOff;
  end

  // Pulse outputs; a hit suppresses the toggle of the same cycle
  always_comb begin
    toggleNext = 1'b0;
    scoreNext  = 1'b0;
    if (enable && (state == StActive)) begin
      scoreNext  = hitPulse;
      toggleNext = TogEn && startOfFrame && !hitPulse && (sofCnt < Lifetime)
                   && ((sofCnt % TogDiv) == '0);
    end
  end

  // Frame counter, spawn delay and random source
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      frameCnt    <= '0;
      spawnTarget <= SpawnMin;
      lfsr        <= LfsrSeed;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      if (stateNext != state)  frameCnt <= '0;
      else if (startOfFrame)   frameCnt <= sofCnt;
      if ((stateNext == StWait) && (state != StWait))
        spawnTarget <= SpawnMin + CntW'(lfsr[5:0]);
    end
  end

  // Registered outputs, aligned with the state they describe
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      idleN      <= 1'b0;
      exploding  <= 1'b0;
      toggleY    <= 1'b0;
      scorePulse <= 1'b0;
    end else begin
      idleN      <= (stateNext == StActive);
      exploding  <= (stateNext == StExplode);
      toggleY    <= toggleNext;
      scorePulse <= scoreNext;
    end
  end

endmodule

// File: tb/tb_lrrr_controller.sv
// Scenario bench for lrrr_controller with an independent LFSR model and a toggle-frame scoreboard.
module tb_lrrr_controller;

  logic clk = 1'b0;
  logic resetN, startOfFrame, enable, hitPulse;
  logic idleN, toggleY, exploding, scorePulse;

  int checks = 0;
  int errors = 0;
  int toggleSeen = 0;
  int scoreSeen = 0;
  int toggleQ[$];
  logic [7:0] mdlLfsr, lfsrPrev, sofLfsr, entryLfsr;
  logic [3:0] sofSnap, hitSnap;
  int n;

  lrrr_controller dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .enable(enable),
    .hitPulse(hitPulse), .idleN(idleN), .toggleY(toggleY), .exploding(exploding),
    .scorePulse(scorePulse)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] snap();
    return {idleN, toggleY, exploding, scorePulse};
  endfunction

  task automatic checkVal(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // One clock: drive, clock, then sample 1ns after the edge
  task automatic tick(input logic sof, input logic hit);
    startOfFrame = sof;
    hitPulse     = hit;
    lfsrPrev     = mdlLfsr;
    @(posedge clk);
    if (resetN) mdlLfsr = {mdlLfsr[6:0], ^(mdlLfsr & 8'hB8)};
    #1;
    startOfFrame = 1'b0;
    hitPulse     = 1'b0;
    if (toggleY)    toggleSeen++;
    if (scorePulse) scoreSeen++;
  endtask

  // Four-clock frame; hitSlot selects which clock carries a hit (-1 for none)
  task automatic frame(input int hitSlot);
    tick(1'b1, hitSlot == 0);
    sofLfsr = lfsrPrev;
    sofSnap = snap();
    if (hitSlot == 0) hitSnap = sofSnap;
    for (int i = 1; i < 4; i++) begin
      tick(1'b0, hitSlot == i);
      if (hitSlot == i) hitSnap = snap();
    end
  endtask

  task automatic doReset(input string tag);
    #2 resetN = 1'b0;
    #1 checkVal(tag, snap(), 0);
    mdlLfsr = 8'hA5;
    enable  = 1'b0;
    #1 resetN = 1'b1;
  endtask

  // Reset, enable when the model LFSR has zero low bits, and count frames to spawn
  task automatic startActive(input string tag);
    int k;
    k = 0;
    doReset({tag, "Rst"});
    while (mdlLfsr[5:0] != 6'd0 && k < 300) begin
      tick(1'b0, 1'b0);
      k++;
    end
    enable = 1'b1;
    tick(1'b0, 1'b0);
    toggleSeen = 0;
    scoreSeen  = 0;
    k = 0;
    while (!idleN && k < 200) begin
      frame(-1);
      k++;
    end
    checkVal({tag, "Spawn"}, k, 60);
    checkVal({tag, "WaitQuiet"}, toggleSeen + scoreSeen, 0);
    toggleSeen = 0;
    scoreSeen  = 0;
  endtask

  task automatic countSpawn(input string tag, input int start, input logic [7:0] ent);
    int k;
    k = start;
    while (!idleN && k < 200) begin
      frame(-1);
      k++;
    end
    checkVal(tag, k, 60 + int'(ent[5:0]));
  endtask

  initial begin
    resetN = 1'b0; enable = 1'b0; startOfFrame = 1'b0; hitPulse = 1'b0;
    mdlLfsr = 8'hA5;
    #1 checkVal("resetOutputs", snap(), 0);
    #2 resetN = 1'b1;
    repeat (5) tick(1'b0, 1'b0);
    checkVal("offWithoutEnable", snap(), 0);

    // Full lifetime: toggles at multiples of 45, unscored exit at 600
    startActive("life");
    for (int k = 1; k <= 13; k++) toggleQ.push_back(45 * k);
    for (int k = 1; k <= 600; k++) begin
      frame(-1);
      if (sofSnap[2]) begin
        if (toggleQ.size() > 0) checkVal("toggleFrame", k, toggleQ.pop_front());
        else                    checkVal("toggleExtra", k, 0);
      end
      if (k == 599) checkVal("activeAt599", sofSnap, 4'b1000);
    end
    checkVal("lifetimeExit", sofSnap, 0);
    checkVal("toggleLeft", toggleQ.size(), 0);
    checkVal("toggleWidth", toggleSeen, 13);
    checkVal("noScoreLifetime", scoreSeen, 0);
    entryLfsr = sofLfsr;
    countSpawn("respawnLife", 0, entryLfsr);

    // Hit at frame 10, hit during EXPLODE and during WAIT
    startActive("hit");
    for (int k = 1; k <= 10; k++) frame((k == 10) ? 1 : -1);
    checkVal("hitFrame10", hitSnap, 4'b0011);
    n = 0;
    while (exploding && n < 100) begin
      frame((n == 4) ? 2 : -1);
      n++;
      if (n == 5) checkVal("hitInExplode", hitSnap, 4'b0010);
    end
    checkVal("explodeFrames", n, 30);
    checkVal("scoreOnce", scoreSeen, 1);
    checkVal("afterExplode", snap(), 0);
    entryLfsr = sofLfsr;
    frame(1);
    checkVal("hitInWait", hitSnap, 0);
    countSpawn("respawnHit", 1, entryLfsr);
    checkVal("scoreOnceTotal", scoreSeen, 1);

    // Hit coincident with the frame-90 toggle, then enable dropped in EXPLODE
    startActive("tog");
    for (int k = 1; k <= 89; k++) frame(-1);
    frame(0);
    checkVal("hitOnToggle", sofSnap, 4'b0011);
    checkVal("toggleOnly45", toggleSeen, 1);
    repeat (3) frame(-1);
    checkVal("explodeHold", snap(), 4'b0010);
    enable = 1'b0;
    tick(1'b0, 1'b0);
    checkVal("enableOffExplode", snap(), 0);
    repeat (3) frame(-1);
    checkVal("staysOff", snap(), 0);

    // Hit coincident with lifetime expiry
    startActive("exp");
    for (int k = 1; k <= 599; k++) frame(-1);
    frame(0);
    checkVal("hitAtExpiry", sofSnap, 4'b0011);

    // enable low with a hit and a toggle condition in the same cycle
    startActive("ovr");
    for (int k = 1; k <= 44; k++) frame(-1);
    enable = 1'b0;
    frame(0);
    checkVal("enableOverride", sofSnap, 0);
    checkVal("noToggleOverride", toggleSeen, 0);
    checkVal("noScoreOverride", scoreSeen, 0);

    // Asynchronous reset in ACTIVE, then OFF until enable
    startActive("ar");
    repeat (5) frame(-1);
    checkVal("preReset", snap(), 4'b1000);
    doReset("asyncReset");
    repeat (3) frame(-1);
    checkVal("offAfterReset", snap(), 0);
    enable = 1'b1;
    tick(1'b0, 1'b0);
    entryLfsr = lfsrPrev;
    countSpawn("respawnReset", 0, entryLfsr);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
